// File: rtl/mini_alu_pkg.sv
// Shared types and constants for the Mini ALU divide path.
// No logic; imported by the divider and its trial-subtract stage.
package mini_alu_pkg;

   localparam int WIDTH = 6;
   localparam int CNT_W = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } div_state_t;

   localparam logic [WIDTH-1:0] DIV_ZERO_QUOT = '1;

   typedef struct packed {
      logic [WIDTH-1:0] quot;
      logic [WIDTH-1:0] rem;
      logic             dbz;
      logic             ovf;
   } div_res_t;

   function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
      return ~v + WIDTH'(1);
   endfunction

   function automatic logic [WIDTH-1:0] mag_w(input logic [WIDTH-1:0] v);
      return v[WIDTH-1] ? neg_w(v) : v;
   endfunction

endpackage

// File: rtl/div_sub_stage.sv
// Combinational (WIDTH+1)-bit trial subtractor for the restoring divider.
// Zero latency; no flow control.
module div_sub_stage
   import mini_alu_pkg::*;
(
   input  logic [WIDTH:0] minuend,
   input  logic [WIDTH:0] subtrahend,
   output logic [WIDTH:0] diff,
   output logic           borrow
);

   assign {borrow, diff} = {1'b0, minuend} - {1'b0, subtrahend};

endmodule

// File: rtl/mini_alu_divider.sv
// Restoring divider, one quotient bit per clock; MINI_ALU_DIV_SIGNED_EN adds signed_mode.
// Latency: WIDTH cycles start-to-done, 1 cycle for divide by zero.
// Backpressure: start is ignored while busy; operands are latched only on acceptance.
module mini_alu_divider
   import mini_alu_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
`ifdef MINI_ALU_DIV_SIGNED_EN
   input  logic             signed_mode,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero,
   output logic             overflow
);

   div_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] dvd_q, dvd_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH-1:0] prem_q, prem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   div_res_t         res_q, res_d;
`ifdef MINI_ALU_DIV_SIGNED_EN
   logic             qneg_q, qneg_d;
   logic             rneg_q, rneg_d;
   logic             ovf_q, ovf_d;
`endif

   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   diff;
   logic             borrow;
   logic [WIDTH:0]   step_rem;
   logic [WIDTH-1:0] step_quo;
   logic [WIDTH-1:0] op_dvd, op_dvs;
   logic [WIDTH-1:0] fin_quo, fin_rem;
   logic             unused_rem_msb;

   // Partial remainder gains the next dividend bit, MSB first.
   assign shifted = {prem_q, dvd_q[WIDTH-1]};

   div_sub_stage u_sub (
      .minuend    (shifted),
      .subtrahend ({1'b0, dvs_q}),
      .diff       (diff),
      .borrow     (borrow)
   );

   assign step_rem       = borrow ? shifted : diff;
   assign step_quo       = {quo_q[WIDTH-2:0], ~borrow};
   // A restored remainder is always below the divisor, so its top bit is zero.
   assign unused_rem_msb = step_rem[WIDTH];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      prem_d  = prem_q;
      quo_d   = quo_q;
      res_d   = res_q;
      op_dvd  = dividend;
      op_dvs  = divisor;
      fin_quo = step_quo;
      fin_rem = step_rem[WIDTH-1:0];
`ifdef MINI_ALU_DIV_SIGNED_EN
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      ovf_d   = ovf_q;
      if (signed_mode) begin
         op_dvd = mag_w(dividend);
         op_dvs = mag_w(divisor);
      end
      if (qneg_q) fin_quo = neg_w(step_quo);
      if (rneg_q) fin_rem = neg_w(step_rem[WIDTH-1:0]);
`endif

      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (start) begin
               if (divisor == '0) begin
                  res_d   = '{quot: DIV_ZERO_QUOT, rem: dividend, dbz: 1'b1, ovf: 1'b0};
                  state_d = DONE;
               end else begin
                  dvd_d   = op_dvd;
                  dvs_d   = op_dvs;
                  prem_d  = '0;
                  quo_d   = '0;
                  cnt_d   = '0;
                  state_d = CALC;
`ifdef MINI_ALU_DIV_SIGNED_EN
                  qneg_d  = signed_mode & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                  rneg_d  = signed_mode & dividend[WIDTH-1];
                  ovf_d   = signed_mode && (dividend == {1'b1, {(WIDTH-1){1'b0}}})
                                        && (divisor == '1);
`endif
               end
            end
         end
         CALC: begin
            prem_d = step_rem[WIDTH-1:0];
            dvd_d  = dvd_q << 1;
            quo_d  = step_quo;
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH-1)) begin
               res_d.quot = fin_quo;
               res_d.rem  = fin_rem;
               res_d.dbz  = 1'b0;
`ifdef MINI_ALU_DIV_SIGNED_EN
               res_d.ovf  = ovf_q;
`else
               res_d.ovf  = 1'b0;
`endif
               state_d    = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         prem_q  <= '0;
         quo_q   <= '0;
         res_q   <= '0;
`ifdef MINI_ALU_DIV_SIGNED_EN
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         prem_q  <= prem_d;
         quo_q   <= quo_d;
         res_q   <= res_d;
`ifdef MINI_ALU_DIV_SIGNED_EN
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign busy        = (state_q == CALC);
   assign done        = (state_q == DONE);
   assign quotient    = res_q.quot;
   assign remainder   = res_q.rem;
   assign div_by_zero = res_q.dbz;
   assign overflow    = res_q.ovf;

endmodule

// File: tb/tb_mini_alu_divider.sv
// Self-checking bench for mini_alu_divider: vector table, scoreboard queue, corner-case sequences.
// Signed cases are compiled in when MINI_ALU_DIV_SIGNED_EN is defined.
module tb_mini_alu_divider;

   localparam int W = 6;

   typedef struct {
      logic [W-1:0] dvd;
      logic [W-1:0] dvs;
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dbz;
      logic         ovf;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] dividend = '0;
   logic [W-1:0] divisor = '0;
`ifdef MINI_ALU_DIV_SIGNED_EN
   logic         signed_mode = 1'b0;
`endif
   logic         busy, done, div_by_zero, overflow;
   logic [W-1:0] quotient, remainder;

   int   tests = 0;
   int   fails = 0;
   vec_t sb_q[$];

   mini_alu_divider dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
`ifdef MINI_ALU_DIV_SIGNED_EN
      .signed_mode (signed_mode),
`endif
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero),
      .overflow    (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Scoreboard: every done pulse must match the oldest outstanding request.
   always @(negedge clk) begin
      if (rst_n && done) begin
         if (sb_q.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            vec_t e;
            e = sb_q.pop_front();
            check("quotient",    32'(quotient),    32'(e.q));
            check("remainder",   32'(remainder),   32'(e.r));
            check("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
            check("overflow",    32'(overflow),    32'(e.ovf));
         end
      end
   end

   // Called #1 after an edge; lat is the number of further edges until done.
   task automatic wait_done(input int lat);
      int cyc = 0;
      while (!done && cyc < 20) begin
         check("busy_during_calc", 32'(busy), 32'd1);
         @(posedge clk); #1;
         cyc++;
      end
      if (!done) begin
         check("done_timeout", 32'(cyc), 32'(lat));
      end else begin
         check("latency", 32'(cyc), 32'(lat));
         check("busy_at_done", 32'(busy), 32'd0);
      end
   endtask

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] q, input logic [W-1:0] r,
                         input logic dbz, input logic ovf, input bit b2b);
      vec_t e;
      if (!b2b) @(negedge clk);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      e = '{dvd: a, dvs: b, q: q, r: r, dbz: dbz, ovf: ovf};
      sb_q.push_back(e);
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(dbz ? 0 : W);
   endtask

   vec_t vecs[10];

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "simulation time limit");
   end

   initial begin
      vecs[0] = '{dvd: 6'd45, dvs: 6'd7,  q: 6'd6,  r: 6'd3,  dbz: 1'b0, ovf: 1'b0};
      vecs[1] = '{dvd: 6'd63, dvs: 6'd1,  q: 6'd63, r: 6'd0,  dbz: 1'b0, ovf: 1'b0};
      vecs[2] = '{dvd: 6'd5,  dvs: 6'd63, q: 6'd0,  r: 6'd5,  dbz: 1'b0, ovf: 1'b0};
      vecs[3] = '{dvd: 6'd5,  dvs: 6'd0,  q: 6'd63, r: 6'd5,  dbz: 1'b1, ovf: 1'b0};
      vecs[4] = '{dvd: 6'd0,  dvs: 6'd5,  q: 6'd0,  r: 6'd0,  dbz: 1'b0, ovf: 1'b0};
      vecs[5] = '{dvd: 6'd62, dvs: 6'd31, q: 6'd2,  r: 6'd0,  dbz: 1'b0, ovf: 1'b0};
      vecs[6] = '{dvd: 6'd7,  dvs: 6'd45, q: 6'd0,  r: 6'd7,  dbz: 1'b0, ovf: 1'b0};
      vecs[7] = '{dvd: 6'd0,  dvs: 6'd0,  q: 6'd63, r: 6'd0,  dbz: 1'b1, ovf: 1'b0};
      vecs[8] = '{dvd: 6'd33, dvs: 6'd33, q: 6'd1,  r: 6'd0,  dbz: 1'b0, ovf: 1'b0};
      vecs[9] = '{dvd: 6'd50, dvs: 6'd8,  q: 6'd6,  r: 6'd2,  dbz: 1'b0, ovf: 1'b0};

      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_quotient", 32'(quotient), 32'd0);
      check("rst_remainder", 32'(remainder), 32'd0);
      check("rst_dbz", 32'(div_by_zero), 32'd0);
      check("rst_ovf", 32'(overflow), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i])
         run_op(vecs[i].dvd, vecs[i].dvs, vecs[i].q, vecs[i].r, vecs[i].dbz, vecs[i].ovf, 1'b0);

      // Result holds after done until the next result.
      repeat (3) @(posedge clk);
      #1;
      check("hold_quotient", 32'(quotient), 32'd6);
      check("hold_remainder", 32'(remainder), 32'd2);

      for (int k = 0; k < 8; k++) begin
         logic [W-1:0] a, b, q, r;
         a = W'($urandom_range(0, 63));
         b = W'($urandom_range(1, 63));
         q = a / b;
         r = a % b;
         run_op(a, b, q, r, 1'b0, 1'b0, 1'b0);
      end

      // Back-to-back: start held during the done cycle launches the next divide.
      run_op(6'd45, 6'd7, 6'd6, 6'd3, 1'b0, 1'b0, 1'b0);
      run_op(6'd20, 6'd6, 6'd3, 6'd2, 1'b0, 1'b0, 1'b1);
      run_op(6'd9,  6'd0, 6'd63, 6'd9, 1'b1, 1'b0, 1'b1);

      // Second start mid-divide is ignored and its operands are not resampled.
      begin
         vec_t e;
         @(negedge clk);
         dividend = 6'd45;
         divisor  = 6'd7;
         start    = 1'b1;
         e = '{dvd: 6'd45, dvs: 6'd7, q: 6'd6, r: 6'd3, dbz: 1'b0, ovf: 1'b0};
         sb_q.push_back(e);
         @(posedge clk); #1;
         start = 1'b0;
         repeat (2) @(posedge clk);
         #1;
         dividend = 6'd9;
         divisor  = 6'd2;
         start    = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
         wait_done(3);
      end
      run_op(6'd9, 6'd2, 6'd4, 6'd1, 1'b0, 1'b0, 1'b0);

      // Reset mid-divide discards the operation and clears every output at once.
      @(negedge clk);
      dividend = 6'd45;
      divisor  = 6'd7;
      start    = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      check("midrst_quotient", 32'(quotient), 32'd0);
      check("midrst_remainder", 32'(remainder), 32'd0);
      check("midrst_dbz", 32'(div_by_zero), 32'd0);
      check("midrst_ovf", 32'(overflow), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      check("postrst_idle_busy", 32'(busy), 32'd0);
      run_op(6'd20, 6'd4, 6'd5, 6'd0, 1'b0, 1'b0, 1'b0);

`ifdef MINI_ALU_DIV_SIGNED_EN
      signed_mode = 1'b1;
      run_op(6'b101100, 6'd3,      6'b111010, 6'b111110, 1'b0, 1'b0, 1'b0);
      run_op(6'd20,     6'b111101, 6'b111010, 6'd2,      1'b0, 1'b0, 1'b0);
      run_op(6'b100000, 6'b111111, 6'b100000, 6'd0,      1'b0, 1'b1, 1'b0);
      run_op(6'b111011, 6'd0,      6'd63,     6'b111011, 1'b1, 1'b0, 1'b0);
      run_op(6'b101100, 6'b111101, 6'd6,      6'b111110, 1'b0, 1'b0, 1'b0);
      signed_mode = 1'b0;
      run_op(6'b101100, 6'd3,      6'd14,     6'd2,      1'b0, 1'b0, 1'b0);
`endif

      repeat (3) @(posedge clk);
      #1;
      check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
